// File: rtl/sobel_pkg.sv
// Shared definitions for the 3x3 Sobel window fetcher: direction codes, FSM
// states and the per-direction slot order used during a 3-pixel fetch.
package sobel_pkg;

    localparam int WIN_SLOTS     = 9;
    localparam int PIX_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        DIR_HOLD  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_ROW   = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        FETCH_ALL = 2'b01,
        FETCH_3   = 2'b10,
        DONE      = 2'b11
    } state_e;

    // Slot fetched at a given step of a shift: the column or row that the
    // shift left stale, walked top-to-bottom or left-to-right.
    function automatic logic [3:0] fetch3_slot(input dir_e dir, input logic [1:0] step);
        logic [3:0] slot;
        slot = 4'd0;
        case (dir)
            DIR_RIGHT: begin
                case (step)
                    2'd0:    slot = 4'd2;
                    2'd1:    slot = 4'd5;
                    default: slot = 4'd8;
                endcase
            end
            DIR_LEFT: begin
                case (step)
                    2'd0:    slot = 4'd0;
                    2'd1:    slot = 4'd3;
                    default: slot = 4'd6;
                endcase
            end
            DIR_ROW: begin
                case (step)
                    2'd0:    slot = 4'd6;
                    2'd1:    slot = 4'd7;
                    default: slot = 4'd8;
                endcase
            end
            default: slot = 4'd0;
        endcase
        return slot;
    endfunction

endpackage

// File: rtl/sobel_window_if.sv
// Pixel read channel between the window fetcher (master) and pixel memory (slave).
interface sobel_window_if #(
    parameter int PIX_W = 8
);
    logic             pix_req;
    logic [3:0]       pix_idx;
    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;

    modport master (
        output pix_req,
        output pix_idx,
        input  pix_data,
        input  pix_valid
    );

    modport slave (
        input  pix_req,
        input  pix_idx,
        output pix_data,
        output pix_valid
    );
endinterface

// File: rtl/sobel_window.sv
// 3x3 pixel window register with full reload and right/left/next-row shifts
// that refetch only the stale column or row over a req/valid pixel channel.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for load_initial or start_shift
//   FETCH_ALL | fetching slots 0..8 in order
//   FETCH_3   | window already shifted, fetching the 3 stale slots
//   DONE      | one-cycle load_done pulse, then back to IDLE
module sobel_window
    import sobel_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       n_reset,
    input  logic                       load_initial,
    input  logic                       start_shift,
    input  logic [1:0]                 direction,
    sobel_window_if.master             pix,
    output logic [WIN_SLOTS*PIX_W-1:0] window,
    output logic                       window_valid,
    output logic                       busy,
    output logic                       load_done
);

    state_e           state;
    state_e           state_nxt;
    logic [3:0]       step;
    dir_e             dir_q;
    dir_e             dir_in;
    logic [3:0]       slot_idx;
    logic             last_slot;
    logic             start_all;
    logic             shift_en;
    logic             capture;
    logic [PIX_W-1:0] win [WIN_SLOTS];

    assign dir_in = dir_e'(direction);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_all = 1'b0;
        shift_en  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (load_initial) begin
                    state_nxt = FETCH_ALL;
                    start_all = 1'b1;
                end else if (start_shift) begin
                    if (dir_in == DIR_HOLD) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FETCH_3;
                        shift_en  = 1'b1;
                    end
                end
            end
            FETCH_ALL, FETCH_3: begin
                if (pix.pix_valid) begin
                    capture = 1'b1;
                    if (last_slot) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        slot_idx  = 4'd0;
        last_slot = 1'b0;
        case (state)
            FETCH_ALL: begin
                slot_idx  = step;
                last_slot = (step == 4'd8);
            end
            FETCH_3: begin
                slot_idx  = fetch3_slot(dir_q, step[1:0]);
                last_slot = (step == 4'd2);
            end
            default: begin
                slot_idx  = 4'd0;
                last_slot = 1'b0;
            end
        endcase
    end

    // A shift moves the surviving pixels on the accepting edge; the stale
    // column/row keeps old data until its fetch overwrites it.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            step         <= 4'd0;
            dir_q        <= DIR_HOLD;
            window_valid <= 1'b0;
            for (int k = 0; k < WIN_SLOTS; k++) begin
                win[k] <= '0;
            end
        end else begin
            if (start_all) begin
                step         <= 4'd0;
                window_valid <= 1'b0;
            end
            if (shift_en) begin
                step         <= 4'd0;
                dir_q        <= dir_in;
                window_valid <= 1'b0;
                for (int i = 0; i < 3; i++) begin
                    case (dir_in)
                        DIR_RIGHT: begin
                            win[3*i]   <= win[3*i+1];
                            win[3*i+1] <= win[3*i+2];
                        end
                        DIR_LEFT: begin
                            win[3*i+2] <= win[3*i+1];
                            win[3*i+1] <= win[3*i];
                        end
                        DIR_ROW: begin
                            win[i]     <= win[i+3];
                            win[i+3]   <= win[i+6];
                        end
                        default: ;
                    endcase
                end
            end
            if (capture) begin
                win[slot_idx] <= pix.pix_data;
                step          <= step + 4'd1;
                if (last_slot) begin
                    window_valid <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < WIN_SLOTS; g++) begin : g_window
        assign window[g*PIX_W +: PIX_W] = win[g];
    end

    assign busy        = (state == FETCH_ALL) || (state == FETCH_3);
    assign load_done   = (state == DONE);
    assign pix.pix_req = busy;
    assign pix.pix_idx = slot_idx;

endmodule

// File: tb/tb_sobel_window.sv
// Randomized bench for sobel_window: a slot-array model of the 3x3 window,
// a pixel responder with programmable latency, and directed reset/priority cases.
module tb_sobel_window;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        load_initial;
    logic        start_shift;
    logic [1:0]  direction;
    logic [71:0] window;
    logic        window_valid;
    logic        busy;
    logic        load_done;

    sobel_window_if #(.PIX_W(8)) pix_if ();

    sobel_window #(.PIX_W(8)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .load_initial (load_initial),
        .start_shift  (start_shift),
        .direction    (direction),
        .pix          (pix_if),
        .window       (window),
        .window_valid (window_valid),
        .busy         (busy),
        .load_done    (load_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int exp_win [9];
    bit exp_valid;
    int exp_seq [$];
    int fx [$];
    int none [$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [71:0] exp_packed();
        logic [71:0] p;
        for (int k = 0; k < 9; k++) p[k*8 +: 8] = exp_win[k][7:0];
        return p;
    endfunction

    // Window as a 3x3 grid: a shift copies each surviving pixel from its
    // neighbour; the vacated column/row is what gets fetched.
    function automatic void model_shift(input logic [1:0] dir);
        int old [9];
        old = exp_win;
        exp_seq = {};
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                case (dir)
                    2'b01: if (c < 2) exp_win[3*r+c] = old[3*r+c+1];
                    2'b10: if (c > 0) exp_win[3*r+c] = old[3*r+c-1];
                    2'b11: if (r < 2) exp_win[3*r+c] = old[3*(r+1)+c];
                    default: ;
                endcase
            end
        end
        for (int i = 0; i < 3; i++) begin
            case (dir)
                2'b01: exp_seq.push_back(3*i + 2);
                2'b10: exp_seq.push_back(3*i);
                2'b11: exp_seq.push_back(6 + i);
                default: ;
            endcase
        end
    endfunction

    // Starts and ends on a falling edge.
    task automatic do_op(input string tag, input bit is_load, input bit both,
                         input logic [1:0] dir, input int lat, input bit poke,
                         input int fixed [$]);
        int nb;
        logic [7:0] d;
        if (is_load) begin
            exp_seq = {};
            for (int k = 0; k < 9; k++) exp_seq.push_back(k);
        end else begin
            model_shift(dir);
        end
        load_initial = is_load;
        start_shift  = !is_load || both;
        direction    = dir;
        @(negedge clk);
        load_initial = 1'b0;
        start_shift  = 1'b0;
        if (exp_seq.size() == 0) begin
            chk({tag, " hold load_done"}, load_done, 1'b1);
            chk({tag, " hold pix_req"}, pix_if.pix_req, 1'b0);
            chk({tag, " hold busy"}, busy, 1'b0);
            chk({tag, " hold window"}, window, exp_packed());
            chk({tag, " hold window_valid"}, window_valid, exp_valid);
            @(negedge clk);
            chk({tag, " hold load_done end"}, load_done, 1'b0);
            return;
        end
        nb = 0;
        for (int i = 0; i < exp_seq.size(); i++) begin
            for (int w = 0; w <= lat; w++) begin
                chk({tag, " pix_req"}, pix_if.pix_req, 1'b1);
                chk({tag, " pix_idx"}, pix_if.pix_idx, exp_seq[i]);
                chk({tag, " window_valid low"}, window_valid, 1'b0);
                chk({tag, " load_done low"}, load_done, 1'b0);
                if (busy) nb++;
                if (poke && i == 2 && w == 0) begin
                    start_shift  = 1'b1;
                    load_initial = $urandom_range(0, 1);
                    direction    = 2'($urandom_range(1, 3));
                end else begin
                    start_shift  = 1'b0;
                    load_initial = 1'b0;
                end
                if (w == lat) begin
                    d = (fixed.size() > i) ? 8'(fixed[i]) : 8'($urandom);
                    pix_if.pix_valid = 1'b1;
                    pix_if.pix_data  = d;
                    exp_win[exp_seq[i]] = d;
                end else begin
                    pix_if.pix_valid = 1'b0;
                    pix_if.pix_data  = 8'($urandom);
                end
                @(negedge clk);
            end
        end
        pix_if.pix_valid = 1'b0;
        start_shift      = 1'b0;
        load_initial     = 1'b0;
        exp_valid        = 1'b1;
        chk({tag, " busy cycles"}, nb, exp_seq.size() * (lat + 1));
        chk({tag, " load_done"}, load_done, 1'b1);
        chk({tag, " pix_req end"}, pix_if.pix_req, 1'b0);
        chk({tag, " busy end"}, busy, 1'b0);
        chk({tag, " window"}, window, exp_packed());
        chk({tag, " window_valid"}, window_valid, 1'b1);
        @(negedge clk);
        chk({tag, " load_done pulse"}, load_done, 1'b0);
        chk({tag, " idle busy"}, busy, 1'b0);
        // A stray valid while nothing is requested must not touch the window.
        pix_if.pix_valid = 1'b1;
        pix_if.pix_data  = 8'($urandom);
        @(negedge clk);
        pix_if.pix_valid = 1'b0;
        chk({tag, " stray valid window"}, window, exp_packed());
        chk({tag, " stray valid pix_req"}, pix_if.pix_req, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " window"}, window, 72'h0);
        chk({tag, " window_valid"}, window_valid, 1'b0);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " load_done"}, load_done, 1'b0);
        chk({tag, " pix_req"}, pix_if.pix_req, 1'b0);
        chk({tag, " pix_idx"}, pix_if.pix_idx, 4'd0);
    endtask

    initial begin
        n_reset          = 1'b0;
        load_initial     = 1'b0;
        start_shift      = 1'b0;
        direction        = 2'b00;
        pix_if.pix_valid = 1'b0;
        pix_if.pix_data  = 8'h00;
        for (int k = 0; k < 9; k++) exp_win[k] = 0;
        exp_valid = 1'b0;
        none = {};
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        n_reset = 1'b1;
        @(negedge clk);

        fx = {10, 11, 12, 13, 14, 15, 16, 17, 18};
        do_op("load10", 1'b1, 1'b0, 2'b00, 0, 1'b0, fx);
        chk("load10 const", window, 72'h12_11_10_0f_0e_0d_0c_0b_0a);

        fx = {20, 21, 22};
        do_op("right", 1'b0, 1'b0, 2'b01, 0, 1'b0, fx);
        chk("right const", window, 72'h16_12_11_15_0f_0e_14_0c_0b);

        fx = {30, 31, 32};
        do_op("left", 1'b0, 1'b0, 2'b10, 0, 1'b0, fx);
        chk("left const", window, 72'h12_11_20_0f_0e_1f_0c_0b_1e);

        do_op("row_slow", 1'b0, 1'b0, 2'b11, 2, 1'b0, none);
        do_op("both_poke", 1'b1, 1'b1, 2'b01, 1, 1'b1, none);
        do_op("hold", 1'b0, 1'b0, 2'b00, 0, 1'b0, none);

        // Reset after four captures of a full fetch.
        load_initial = 1'b1;
        @(negedge clk);
        load_initial = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pix_if.pix_valid = 1'b1;
            pix_if.pix_data  = 8'($urandom);
            @(negedge clk);
        end
        pix_if.pix_valid = 1'b0;
        #1 n_reset = 1'b0;
        #1 chk_reset_outputs("midreset");
        for (int k = 0; k < 9; k++) exp_win[k] = 0;
        exp_valid = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post reset load_done", load_done, 1'b0);
            chk("post reset busy", busy, 1'b0);
        end
        do_op("reload", 1'b1, 1'b0, 2'b00, $urandom_range(0, 2), 1'b0, none);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                do_op("rnd_load", 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), none);
            end else begin
                do_op("rnd_shift", 1'b0, 1'b0, 2'($urandom_range(0, 3)),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), none);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sobel_window.md
SOBEL_WINDOW -- requirements
Module: sobel_window

Interface
REQ-001 SHALL have parameter: PIX_W, 8, pixel width in bits.
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: n_reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: load_initial  input  1  request a full 9-pixel window fetch.
REQ-005 SHALL have port: start_shift  input  1  request a window shift plus a 3-pixel fetch.
REQ-006 SHALL have port: direction  input  2  shift direction, sampled with start_shift: 01 right, 10 left, 11 next row, 00 hold.
REQ-007 SHALL have port: pix_req  output  1  pixel read request to the memory side.
REQ-008 SHALL have port: pix_idx  output  4  window slot 0..8 (row-major, slot = 3*row+col) being requested.
REQ-009 SHALL have port: pix_data  input  PIX_W  returned pixel.
REQ-010 SHALL have port: pix_valid  input  1  pix_data valid for the current pix_idx.
REQ-011 SHALL have port: window  output  9*PIX_W  slot k at bits [k*PIX_W +: PIX_W].
REQ-012 SHALL have port: window_valid  output  1  window complete and stable.
REQ-013 SHALL have port: busy  output  1  fetch in progress.
REQ-014 SHALL have port: load_done  output  1  one-cycle pulse when a fetch or hold completes.

Function
REQ-015 FSM states SHALL be IDLE, FETCH_ALL, FETCH_3 and DONE; DONE lasts one cycle, drives load_done=1, then returns to IDLE.
REQ-016 In IDLE, load_initial=1 SHALL enter FETCH_ALL with slot sequence 0..8 and clear window_valid.
REQ-017 In IDLE, start_shift=1 with load_initial=0 SHALL shift the window on that edge and enter FETCH_3.
REQ-018 Right shift SHALL move col1->col0 and col2->col1, then fetch slots 2,5,8 in that order.
REQ-019 Left shift SHALL move col1->col2 and col0->col1, then fetch slots 0,3,6 in that order.
REQ-020 Next-row shift SHALL move row1->row0 and row2->row1, then fetch slots 6,7,8 in that order.
REQ-021 direction=00 SHALL leave the window unchanged and go directly to DONE, with no pix_req.
REQ-022 When load_initial and start_shift are both high in IDLE, load_initial SHALL win.
REQ-023 load_initial and start_shift SHALL be ignored outside IDLE; busy=1 in FETCH_ALL and FETCH_3.
REQ-024 pix_req SHALL be high in FETCH states, with pix_idx stable until a cycle in which pix_valid=1.
REQ-025 On each edge where pix_req and pix_valid are both high, pix_data SHALL be written to slot pix_idx and the sequence SHALL advance.
REQ-026 pix_valid SHALL be ignored while pix_req=0.
REQ-027 Capture of the last slot in a sequence SHALL deassert pix_req on the next edge and enter DONE.
REQ-028 With pix_valid tied high, FETCH_ALL SHALL take 9 cycles and FETCH_3 SHALL take 3 cycles.
REQ-029 window_valid SHALL go low on entry to any FETCH state and high on entry to DONE; hold SHALL keep the current value.

Reset
REQ-030 n_reset=0 SHALL immediately force IDLE and set window=0, window_valid=0, busy=0, load_done=0, pix_req=0 and pix_idx=0.
REQ-031 Reset asserted mid-fetch SHALL abandon the sequence, and no load_done SHALL follow.

Structure
REQ-032 Package sobel_pkg SHALL hold the direction encodings (DIR_HOLD, DIR_RIGHT, DIR_LEFT, DIR_ROW), the state enum, WIN_SLOTS=9 and the default PIX_W; the same direction encodings SHALL be shared with the address/move controller.
REQ-033 No sub-module SHALL be used; the slot sequence SHALL be a small lookup indexed by direction and a 2-bit step counter (4-bit counter in FETCH_ALL).

Verification
REQ-034 Reset, then load_initial with pix_valid=1 returning data 10..18 for slots 0..8 -> window = 10..18, load_done pulses at cycle 10, window_valid=1.
REQ-035 From that window, right shift with data 20,21,22 -> slots = 11,12,20,14,15,21,17,18,22, pix_idx sequence 2,5,8.
REQ-036 Left shift with data 30,31,32 -> col2 = old col1, col1 = old col0, slots 0,3,6 = 30,31,32.
REQ-037 Next-row shift with pix_valid delayed 2 cycles per pixel -> pix_idx held stable for 3 cycles each, 9 busy cycles, row2 = new data.
REQ-038 load_initial and start_shift together, then start_shift pulsed mid-fetch -> full 9-slot fetch only, second request ignored; direction=00 -> load_done the next cycle, no pix_req.
REQ-039 n_reset asserted after 4 captures of FETCH_ALL -> all outputs 0 immediately, no load_done, and a subsequent load_initial completes normally.
